// File: rtl/log_dump_ctrl_pkg.sv
// Shared definitions for the log memory dump controller.
package log_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StWait  = 3'd2,
    StLatch = 3'd3,
    StSend  = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_serializer.sv
// Holds one log word and presents it a byte at a time, MSB first.
module word_serializer
  import log_dump_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          advance,
  input  logic [8*BYTES_PER_WORD-1:0]   word,
  output logic [7:0]                    tx_data,
  output logic                          last
);

  logic [8*BYTES_PER_WORD-1:0] shift_q;
  logic [1:0]                  idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      shift_q <= word;
      idx_q   <= '0;
    end else if (advance) begin
      shift_q <= {shift_q[8*BYTES_PER_WORD-9:0], 8'h00};
      idx_q   <= idx_q + 2'd1;
    end
  end

  assign tx_data = shift_q[8*BYTES_PER_WORD-1 -: 8];
  assign last    = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/log_dump_ctrl.sv
// Sweeps the full log memory and streams every word out as four bytes.
module log_dump_ctrl
  import log_dump_ctrl_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned BRAM_DATA_WIDTH = 16,
  parameter int unsigned NUM_WORDS       = 2**BRAM_ADDR_WIDTH,
  parameter int unsigned RD_LATENCY      = 1
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_dump_start,
  input  logic                         i_abort,
  input  logic                         i_mem_full,
  input  logic [2*BRAM_DATA_WIDTH-1:0] i_data_log_from_mem,
  output logic                         o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_addr_log_to_mem,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned LatW = $clog2(RD_LATENCY + 1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] LastAddr = BRAM_ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [LatW-1:0] LatLast = LatW'(RD_LATENCY - 1);

  state_e                     state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LatW-1:0]            lat_q, lat_d;
  logic                       abort_q, abort_d;

  logic       stop_req, hs, last_byte;
  logic [7:0] ser_data;

  // Losing the full flag mid-dump is handled exactly like an abort.
  assign stop_req = i_abort | ~i_mem_full;
  assign hs       = (state_q == StSend) & i_tx_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    abort_d = abort_q;
    unique case (state_q)
      StIdle: begin
        if (i_dump_start && i_mem_full) state_d = StArm;
      end
      StArm: begin
        state_d = stop_req ? StIdle : StWait;
        lat_d   = '0;
      end
      StWait: begin
        if (stop_req) begin
          state_d = StIdle;
        end else if (lat_q == LatLast) begin
          state_d = StLatch;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StLatch: begin
        state_d = stop_req ? StIdle : StSend;
      end
      StSend: begin
        // An abort here only takes effect once the pending byte is accepted.
        if (stop_req) abort_d = 1'b1;
        if (hs) begin
          if (abort_q || stop_req) begin
            state_d = StIdle;
          end else if (last_byte) begin
            lat_d = '0;
            if (addr_q == LastAddr) begin
              state_d = StDone;
            end else begin
              addr_d  = addr_q + BRAM_ADDR_WIDTH'(1);
              state_d = StWait;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle || state_d == StDone) begin
      addr_d  = '0;
      lat_d   = '0;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      lat_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      abort_q <= abort_d;
    end
  end

  word_serializer u_ser (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .load    (state_q == StLatch),
    .advance (hs),
    .word    (i_data_log_from_mem),
    .tx_data (ser_data),
    .last    (last_byte)
  );

  assign o_busy            = state_q inside {StArm, StWait, StLatch, StSend};
  assign o_read_log        = o_busy;
  assign o_tx_valid        = (state_q == StSend);
  assign o_tx_data         = o_tx_valid ? ser_data : 8'h00;
  assign o_done            = (state_q == StDone);
  assign o_addr_log_to_mem = addr_q;

endmodule

// File: tb/tb_log_dump_ctrl.sv
// Randomized bench for log_dump_ctrl against a byte-stream reference model.
module tb_log_dump_ctrl;

  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned NW  = 4;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dump_start = 1'b0;
  logic          abort = 1'b0;
  logic          mem_full = 1'b1;
  logic          tx_ready = 1'b1;
  logic [2*DW-1:0] rd_data;
  logic          read_log, tx_valid, busy, done;
  logic [AW-1:0] addr;
  logic [7:0]    tx_data;

  always #5 clk = ~clk;

  log_dump_ctrl #(
    .BRAM_ADDR_WIDTH (AW),
    .BRAM_DATA_WIDTH (DW),
    .NUM_WORDS       (NW),
    .RD_LATENCY      (LAT)
  ) dut (
    .clk                 (clk),
    .i_rst_n             (rst_n),
    .i_dump_start        (dump_start),
    .i_abort             (abort),
    .i_mem_full          (mem_full),
    .i_data_log_from_mem (rd_data),
    .o_read_log          (read_log),
    .o_addr_log_to_mem   (addr),
    .o_tx_data           (tx_data),
    .o_tx_valid          (tx_valid),
    .i_tx_ready          (tx_ready),
    .o_busy              (busy),
    .o_done              (done)
  );

  // Log memory: contents array plus an LAT-stage read pipeline.
  logic [31:0] mem [NW];
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= (int'(addr) < NW) ? mem[int'(addr) % NW] : 32'hDEAD_BEEF;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign rd_data = pipe[LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = mem[(i / 4) % NW];
    return 8'((w >> (8 * (3 - (i % 4)))) & 32'hFF);
  endfunction

  // Monitor: collects accepted bytes and checks handshake/address rules.
  int          cyc = 0;
  logic [7:0]  got_q [$];
  int          done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, hold = 0;
  logic [AW-1:0] prev_addr = '0;
  logic        prev_stall = 1'b0, prev_valid = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid_held", tx_valid, 1);
        check("stall_data_held", tx_data, prev_data);
      end
      hold = (addr == prev_addr) ? hold + 1 : 1;
      if (tx_valid && !prev_valid) begin
        check("addr_held_before_send", hold >= LAT + 2, 1);
        check("addr_in_range", int'(addr) < NW, 1);
        check("read_log_while_send", read_log, 1);
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_valid = tx_valid;
      prev_data  = tx_data;
      prev_addr  = addr;
    end else begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      hold       = 0;
    end
  end

  task automatic step(input bit rand_rdy);
    @(posedge clk);
    #1;
    if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_dump(input bit rand_rdy, output int start_c);
    int d0;
    bit ok;
    d0 = done_cnt;
    got_q.delete();
    @(posedge clk);
    #1;
    dump_start = 1'b1;
    start_c = cyc;
    if (rand_rdy) tx_ready = 1'($urandom_range(0, 1));
    step(rand_rdy);
    dump_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      step(rand_rdy);
    end
    check("dump_completes", ok, 1);
    tx_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int nbytes);
    check({tag, "_len"}, got_q.size(), nbytes);
    for (int i = 0; i < nbytes && i < got_q.size(); i++) check(tag, got_q[i], exp_byte(i));
  endtask

  // Stop a dump mid-byte with ready low, via i_abort or by dropping i_mem_full.
  task automatic stop_case(input bit use_full, input string tag);
    int  d0;
    bit  seen;
    d0 = done_cnt;
    got_q.delete();
    tx_ready = 1'b0;
    step(0);
    dump_start = 1'b1;
    step(0);
    dump_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx_valid) begin
        seen = 1'b1;
        break;
      end
      step(0);
    end
    check({tag, "_reached_send"}, seen, 1);
    if (use_full) mem_full = 1'b0;
    else abort = 1'b1;
    step(0);
    mem_full = 1'b1;
    abort    = 1'b0;
    for (int i = 0; i < 3; i++) step(0);
    check({tag, "_valid_held"}, tx_valid, 1);
    check({tag, "_data_held"}, tx_data, exp_byte(0));
    tx_ready = 1'b1;
    step(0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_valid"}, tx_valid, 0);
    check({tag, "_addr_zero"}, addr, 0);
    for (int i = 0; i < 10; i++) step(0);
    check({tag, "_no_done"}, done_cnt - d0, 0);
    check({tag, "_one_byte"}, got_q.size(), 1);
    if (got_q.size() > 0) check({tag, "_byte"}, got_q[0], exp_byte(0));
  endtask

  initial begin
    int  s, d0;
    bit  bad, seen;

    for (int a = 0; a < NW; a++) mem[a] = 32'hA0B0_C0D0 + 32'(a);
    rst_n = 1'b0;
    #23;
    check("reset_outputs", {24'h0, busy, read_log, tx_valid, done, addr}, 0);
    check("reset_tx_data", tx_data, 0);
    rst_n = 1'b1;
    step(0);

    // Full sweep with the transmitter always ready.
    d0 = done_cnt;
    run_dump(0, s);
    check_stream("seq", NW * 4);
    check("done_after_last_hs", done_cyc - last_hs_cyc, 1);
    check("dump_cycles", done_cyc - s, NW * (LAT + 5) + 2);
    for (int i = 0; i < 3; i++) step(0);
    check("done_once", done_cnt - d0, 1);
    check("busy_after_done", busy, 0);
    check("done_low_after", done, 0);

    // Start request ignored while the memory is not full.
    mem_full = 1'b0;
    dump_start = 1'b1;
    step(0);
    dump_start = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bad |= busy | read_log | tx_valid;
      step(0);
    end
    check("not_full_ignored", bad, 0);
    mem_full = 1'b1;

    // Random backpressure: same pattern, then random memory contents.
    run_dump(1, s);
    check_stream("bp", NW * 4);
    for (int a = 0; a < NW; a++) mem[a] = $urandom;
    run_dump(1, s);
    check_stream("rand", NW * 4);

    stop_case(0, "abort");
    stop_case(1, "full_drop");

    // Asynchronous reset during word 2, then a clean restart.
    tx_ready = 1'b1;
    dump_start = 1'b1;
    step(0);
    dump_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tx_valid && addr == 2) begin
        seen = 1'b1;
        break;
      end
      step(0);
    end
    check("rst_reached_word2", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {27'h0, busy, read_log, tx_valid, done}, 0);
    check("rst_async_addr", addr, 0);
    check("rst_async_data", tx_data, 0);
    step(0);
    step(0);
    rst_n = 1'b1;
    step(0);
    run_dump(0, s);
    check_stream("after_rst", NW * 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
